// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad row/column lines and decoded key event signals
// Ports: col_sync (synchronized active-low columns), row_n (active-low row drive),
//        key_code {row,col}, key_valid (one-cycle strobe), key_held (key locked)
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4
);
  logic [NUM_COLS-1:0] col_sync;
  logic [NUM_ROWS-1:0] row_n;
  logic [$clog2(NUM_ROWS)+$clog2(NUM_COLS)-1:0] key_code;
  logic key_valid;
  logic key_held;
  modport master (input col_sync, output row_n, key_code, key_valid, key_held);
  modport slave (output col_sync, input row_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning keypad controller emitting one debounced event per key press
// Ports: clk (system clock), reset (asynchronous active-high),
//        kp (keypad_scanner_if.master): col_sync in, row_n / key_code / key_valid / key_held out
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every REPEAT_CYCLES clocks.
module keypad_scanner #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 12000000
) (
  input logic clk,
  input logic reset,
  keypad_scanner_if.master kp
);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = $clog2(SCAN_CYCLES) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

  if (NUM_ROWS < 2 || (NUM_ROWS & (NUM_ROWS - 1)) != 0) begin : g_chk_rows
    $error("NUM_ROWS must be a power of two >= 2");
  end
  if (NUM_COLS < 2 || (NUM_COLS & (NUM_COLS - 1)) != 0) begin : g_chk_cols
    $error("NUM_COLS must be a power of two >= 2");
  end
  if (SCAN_CYCLES < 4) begin : g_chk_scan
    $error("SCAN_CYCLES must be >= 4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_chk_rep
    $error("REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t state, state_nx;
  logic [RW-1:0] row, row_nx;
  logic [NUM_ROWS-1:0] row_drv, row_drv_nx;
  logic [NUM_COLS-1:0] pat, pat_nx;
  logic [SW-1:0] scan_cnt, scan_cnt_nx;
  logic [DW-1:0] deb_cnt, deb_cnt_nx;
  logic [RW+CW-1:0] code, code_nx;
  logic valid, valid_nx, held, held_nx;
  logic [NUM_COLS-1:0] low;
  logic one_low, all_ones, cap_low;
  logic [CW-1:0] col_idx;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int PW = $clog2(REPEAT_CYCLES) + 1;
  logic [PW-1:0] rep_cnt, rep_cnt_nx;
`endif

  assign low      = ~kp.col_sync;
  assign one_low  = |low && ~|(low & (low - 1'b1));
  assign all_ones = &kp.col_sync;
  // pat has a single zero at the locked column
  assign cap_low  = |(low & ~pat);

  always_comb begin
    col_idx = '0;
    for (int i = 0; i < NUM_COLS; i++)
      if (!pat[i]) col_idx = CW'(i);
  end

  always_comb begin
    state_nx    = state;
    row_nx      = row;
    pat_nx      = pat;
    scan_cnt_nx = scan_cnt;
    deb_cnt_nx  = deb_cnt;
    code_nx     = code;
    valid_nx    = 1'b0;
    held_nx     = held;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nx  = '0;
`endif
    case (state)
      SCAN:
        if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
          scan_cnt_nx = '0;
          if (one_low) begin
            state_nx   = DEBOUNCE;
            pat_nx     = kp.col_sync;
            deb_cnt_nx = '0;
          end else row_nx = row + 1'b1;
        end else scan_cnt_nx = scan_cnt + 1'b1;
      DEBOUNCE:
        // mismatch is tested first so it beats a completing count
        if (kp.col_sync != pat) begin
          state_nx   = SCAN;
          row_nx     = row + 1'b1;
          deb_cnt_nx = '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES)) begin
          state_nx   = HELD;
          code_nx    = {row, col_idx};
          valid_nx   = 1'b1;
          held_nx    = 1'b1;
          deb_cnt_nx = '0;
        end else deb_cnt_nx = deb_cnt + 1'b1;
      HELD:
        if (all_ones) begin
          state_nx   = RELEASE;
          deb_cnt_nx = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else begin
          valid_nx   = rep_cnt == PW'(REPEAT_CYCLES - 1);
          rep_cnt_nx = valid_nx ? '0 : rep_cnt + 1'b1;
        end
`endif
      RELEASE:
        // the edge that entered RELEASE already saw one all-ones read
        if (cap_low) begin
          state_nx   = HELD;
          deb_cnt_nx = '0;
        end else if (!all_ones) deb_cnt_nx = '0;
        else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_nx    = SCAN;
          row_nx      = row + 1'b1;
          held_nx     = 1'b0;
          deb_cnt_nx  = '0;
          scan_cnt_nx = '0;
        end else deb_cnt_nx = deb_cnt + 1'b1;
      default: state_nx = SCAN;
    endcase
    row_drv_nx = ~(NUM_ROWS'(1) << row_nx);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= SCAN;
      row      <= '0;
      row_drv  <= {{(NUM_ROWS-1){1'b1}}, 1'b0};
      pat      <= '1;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      code     <= '0;
      valid    <= 1'b0;
      held     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      row_drv  <= row_drv_nx;
      pat      <= pat_nx;
      scan_cnt <= scan_cnt_nx;
      deb_cnt  <= deb_cnt_nx;
      code     <= code_nx;
      valid    <= valid_nx;
      held     <= held_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt  <= rep_cnt_nx;
`endif
    end

  assign kp.row_n     = row_drv;
  assign kp.key_code  = code;
  assign kp.key_valid = valid;
  assign kp.key_held  = held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a keypad matrix model, 2-flop column sync and code scoreboard
module tb_keypad_scanner;
  localparam int NR = 4, NC = 4, SC = 4, DC = 8, RC = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic prev_v = 1'b0;
  logic [NC-1:0] keys [NR];
  logic [NC-1:0] raw, s1;
  logic [3:0] exp_q [$];
  int checks = 0;
  int passes = 0;

  keypad_scanner_if #(.NUM_ROWS(NR), .NUM_COLS(NC)) kp ();

  keypad_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_CYCLES(SC),
    .DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    raw = '1;
    for (int r = 0; r < NR; r++)
      if (!kp.row_n[r]) raw = raw & ~keys[r];
  end

  always @(posedge clk) begin
    s1 <= raw;
    kp.col_sync <= s1;
  end

  function automatic logic [NR-1:0] rowv(int r);
    return ~(NR'(1) << r);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row(int r);
    logic [NR-1:0] prev;
    int n;
    prev = kp.row_n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (kp.row_n === rowv(r) && prev !== rowv(r)) break;
      prev = kp.row_n;
    end
    chk($sformatf("reach_row%0d", r), n < 100, 1);
  endtask

  task automatic wait_valid(string tag, int exp_lat);
    int n;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) break;
    end
    chk(tag, n, exp_lat);
  endtask

  always @(negedge clk) begin
    if (!reset && kp.key_valid === 1'b1) begin
      chk("strobe_back_to_back", prev_v, 0);
      chk("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("strobe_code", kp.key_code, exp_q.pop_front());
    end
    prev_v <= kp.key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++) keys[r] = '0;
    tick(3);
    chk("rst_row_n", kp.row_n, 4'b1110);
    chk("rst_valid", kp.key_valid, 0);
    chk("rst_held", kp.key_held, 0);
    chk("rst_code", kp.key_code, 0);
    reset = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      chk("idle_row", kp.row_n, rowv((j / 4) % 4));
      chk("idle_valid", kp.key_valid, 0);
    end
    // row 2 dwell has just started: press row 2 col 1
    keys[2][1] = 1'b1;
    exp_q.push_back(4'b1001);
    wait_valid("press_latency_r2c1", SC + 1 + DC);
    chk("held_at_strobe", kp.key_held, 1);
    tick(30);
    chk("held_while_pressed", kp.key_held, 1);
    chk("row_frozen_held", kp.row_n, rowv(2));
    keys[2] = '0;
    tick(10);
    chk("held_before_release_done", kp.key_held, 1);
    tick(1);
    chk("held_after_release", kp.key_held, 0);
    chk("resume_row3", kp.row_n, rowv(3));
    chk("code_holds", kp.key_code, 4'b1001);
    // bounce on row 1 col 3
    wait_row(1);
    keys[1][3] = 1'b1;
    tick(5);
    keys[1] = '0;
    chk("bounce_row_frozen", kp.row_n, rowv(1));
    tick(3);
    chk("bounce_next_row", kp.row_n, rowv(2));
    chk("bounce_not_held", kp.key_held, 0);
    tick(3);
    chk("bounce_dwell_restart", kp.row_n, rowv(2));
    tick(1);
    chk("bounce_row3", kp.row_n, rowv(3));
    // lock on row 0 col 0 while row 3 col 2 is also pressed
    wait_row(0);
    keys[0][0] = 1'b1;
    exp_q.push_back(4'b0000);
    wait_valid("press_latency_r0c0", SC + 1 + DC);
    keys[3][2] = 1'b1;
    tick(20);
    chk("lock_row_frozen", kp.row_n, rowv(0));
    chk("lock_held", kp.key_held, 1);
    exp_q.push_back(4'b1110);
    keys[0] = '0;
    wait_valid("second_key_latency", (DC + 3) + 2 * SC + SC + 1 + DC);
    keys[3] = '0;
    tick(11);
    chk("second_released", kp.key_held, 0);
    // ghost: two columns on row 1
    wait_row(1);
    keys[1] = 4'b0101;
    tick(4);
    chk("multi_advance", kp.row_n, rowv(2));
    tick(40);
    chk("multi_not_held", kp.key_held, 0);
    keys[1] = '0;
    // reset at debounce count 5
    wait_row(2);
    keys[2][3] = 1'b1;
    tick(SC + 5);
    reset = 1'b1;
    #1;
    chk("async_rst_row_n", kp.row_n, 4'b1110);
    chk("async_rst_valid", kp.key_valid, 0);
    chk("async_rst_held", kp.key_held, 0);
    chk("async_rst_code", kp.key_code, 0);
    keys[2] = '0;
    tick(2);
    reset = 1'b0;
    tick(40);
    chk("after_rst_idle", kp.key_held, 0);
    // long hold on row 1 col 2
    wait_row(1);
    keys[1][2] = 1'b1;
    exp_q.push_back(4'b0110);
    wait_valid("press_latency_r1c2", SC + 1 + DC);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'b0110);
      wait_valid("repeat_interval", RC);
    end
    tick(60 - 3 * RC);
`else
    tick(60);
`endif
    chk("long_hold_held", kp.key_held, 1);
    keys[1] = '0;
    tick(11);
    chk("long_hold_released", kp.key_held, 0);
    tick(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
